// File: rtl/frame_builder_pkg.sv
// Shared frame-builder definitions: tile geometry, entity descriptor layout
// and the no-entity sentinels used by both the DCU and the sprite renderer.
package frame_builder_pkg;

  localparam int unsigned UPSCALE_FACTOR = 5;
  localparam int unsigned TILE_SIZE      = 8;
  localparam int unsigned TILE_LEN_PIXEL = UPSCALE_FACTOR * TILE_SIZE;
  localparam int unsigned SCREEN_SIZE_H  = 16;
  localparam int unsigned SCREEN_SIZE_V  = 12;

  localparam int unsigned DESC_W     = 9;
  localparam int unsigned ROW_LSB    = 6;
  localparam int unsigned ROW_W      = 3;
  localparam int unsigned ID_LSB     = 2;
  localparam int unsigned ID_W       = 4;
  localparam int unsigned ORIENT_LSB = 0;
  localparam int unsigned ORIENT_W   = 2;
  localparam int unsigned ROM_ADDR_W = ID_W + ROW_W;

  localparam logic [DESC_W-1:0] NO_ENTITY      = 9'h1FF;
  localparam logic [ID_W-1:0]   ENTITY_ID_NONE = 4'hF;

  typedef enum logic [ORIENT_W-1:0] {
    ORIENT_NONE    = 2'b00,
    ORIENT_HMIRROR = 2'b01,
    ORIENT_VMIRROR = 2'b10,
    ORIENT_BOTH    = 2'b11
  } orient_e;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [ID_W-1:0]  id;
    orient_e          orient;
  } entity_desc_t;

  function automatic logic mirror_h(input orient_e o);
    return (o == ORIENT_HMIRROR) || (o == ORIENT_BOTH);
  endfunction

  function automatic logic mirror_v(input orient_e o);
    return (o == ORIENT_VMIRROR) || (o == ORIENT_BOTH);
  endfunction

  function automatic logic [ROW_W-1:0] mirror_idx(input logic [ROW_W-1:0] idx,
                                                  input logic             en);
    return en ? (ROW_W'(TILE_SIZE - 1) - idx) : idx;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Combinational sprite ROM: {ID, row} -> 8-bit sprite row, bit 7 leftmost.
// Each glyph is packed as 64 bits with row 0 in the most significant byte.
module sprite_rom
  import frame_builder_pkg::*;
(
  input  logic [ROM_ADDR_W-1:0] addr,
  output logic [7:0]            data
);

  logic [ID_W-1:0]  id;
  logic [ROW_W-1:0] row;
  logic [63:0]      glyph;

  assign id  = addr[ROM_ADDR_W-1:ROW_W];
  assign row = addr[ROW_W-1:0];

  always_comb begin
    glyph = '0;
    case (id)
      4'd0:    glyph = '1;
      4'd1:    glyph = 64'h8040_2010_0804_0201;
      4'd2:    glyph = 64'h3C7E_FFFF_FFFF_7E3C;
      4'd3:    glyph = 64'h66FF_FFFF_7E3C_1800;
      4'd4:    glyph = 64'hFF81_8181_8181_81FF;
      4'd5:    glyph = 64'h1818_18FF_FF18_1818;
      4'd6:    glyph = 64'h080C_FEFF_FFFE_0C08;
      4'd7:    glyph = 64'hAA55_AA55_AA55_AA55;
      4'd8:    glyph = 64'h3C42_8181_8181_423C;
      4'd9:    glyph = 64'h183C_7EFF_FF7E_3C18;
      4'd10:   glyph = 64'hCCCC_CCCC_CCCC_CCCC;
      4'd11:   glyph = 64'hFF00_FF00_FF00_FF00;
      4'd12:   glyph = 64'h3C42_A581_A599_423C;
      4'd13:   glyph = 64'hFFFF_1818_1818_1818;
      4'd14:   glyph = 64'hC3E7_7E3C_3C7E_E7C3;
      default: glyph = '0;
    endcase
    // Row 0 sits in the top byte, so the byte offset is (7 - row) * 8.
    data = glyph[{~row, 3'b000} +: 8];
  end

endmodule

// File: rtl/sprite_pixel_renderer.sv
// Entity-path pixel back end: tracks the column inside the current tile,
// mirrors and fetches the sprite row, and emits foreground bit and entity ID.
module sprite_pixel_renderer #(
  parameter int unsigned UPSCALE_FACTOR = 5,
  parameter int unsigned TILE_SIZE      = 8,
  parameter int unsigned SCREEN_H_PIX   = 640,
  parameter int unsigned SCREEN_V_PIX   = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] entity_in,
  input  logic [9:0] counter_H,
  input  logic [9:0] counter_V,
  output logic       pixel_on,
  output logic       entity_hit,
  output logic [3:0] entity_id
);

  import frame_builder_pkg::*;

  localparam int unsigned SUB_W = (UPSCALE_FACTOR > 1) ? $clog2(UPSCALE_FACTOR) : 1;
  localparam int unsigned COL_W = ROW_W;

  entity_desc_t desc;
  assign desc = entity_desc_t'(entity_in);

  // Column tracker
  logic [SUB_W-1:0] sub_q, sub_d, sub_eff;
  logic [COL_W-1:0] col_q, col_d, col_eff;

  // Stage 0 (decode) and stage 1 (fetch) registers
  logic [ROW_W-1:0] row0_q, row0_d;
  logic [COL_W-1:0] col0_q, col0_d;
  logic [ID_W-1:0]  id0_q, id0_d;
  logic             valid0_q, valid0_d;

  logic [7:0]       rowbyte_q, rowbyte_d;
  logic [COL_W-1:0] col1_q, col1_d;
  logic [ID_W-1:0]  id1_q, id1_d;
  logic             valid1_q, valid1_d;

  logic [7:0]       rom_data;

  // counter_H == 0 forces the tracker to (0,0) in the same cycle, which also
  // recovers from a reset released mid-line.
  always_comb begin
    sub_eff = (counter_H == '0) ? '0 : sub_q;
    col_eff = (counter_H == '0) ? '0 : col_q;
    sub_d   = sub_eff + SUB_W'(1);
    col_d   = col_eff;
    if (sub_eff == SUB_W'(UPSCALE_FACTOR - 1)) begin
      sub_d = '0;
      col_d = (col_eff == COL_W'(TILE_SIZE - 1)) ? '0 : col_eff + COL_W'(1);
    end
  end

  always_comb begin
    row0_d   = mirror_idx(desc.row, mirror_v(desc.orient));
    col0_d   = mirror_idx(col_eff, mirror_h(desc.orient));
    id0_d    = desc.id;
    valid0_d = (entity_in != NO_ENTITY)
             && (32'(counter_H) < SCREEN_H_PIX)
             && (32'(counter_V) < SCREEN_V_PIX);
  end

  sprite_rom u_sprite_rom (
    .addr (ROM_ADDR_W'({id0_q, row0_q})),
    .data (rom_data)
  );

  always_comb begin
    rowbyte_d = rom_data;
    col1_d    = col0_q;
    id1_d     = id0_q;
    valid1_d  = valid0_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_q     <= '0;
      col_q     <= '0;
      row0_q    <= '0;
      col0_q    <= '0;
      id0_q     <= ENTITY_ID_NONE;
      valid0_q  <= 1'b0;
      rowbyte_q <= '0;
      col1_q    <= '0;
      id1_q     <= ENTITY_ID_NONE;
      valid1_q  <= 1'b0;
    end else begin
      sub_q     <= sub_d;
      col_q     <= col_d;
      row0_q    <= row0_d;
      col0_q    <= col0_d;
      id0_q     <= id0_d;
      valid0_q  <= valid0_d;
      rowbyte_q <= rowbyte_d;
      col1_q    <= col1_d;
      id1_q     <= id1_d;
      valid1_q  <= valid1_d;
    end
  end

  // Outputs depend only on stage-1 registers; ~col is 7 - col for 3 bits.
  assign pixel_on   = valid1_q & rowbyte_q[~col1_q];
  assign entity_hit = valid1_q;
  assign entity_id  = valid1_q ? id1_q : ENTITY_ID_NONE;

endmodule

// File: tb/tb_sprite_pixel_renderer.sv
// Scoreboard bench for sprite_pixel_renderer: expectations are queued when
// inputs are driven and compared two cycles later when the output is due.
module tb_sprite_pixel_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] entity_in = 9'h1FF;
  logic [9:0] counter_H = '0;
  logic [9:0] counter_V = '0;
  logic       pixel_on;
  logic       entity_hit;
  logic [3:0] entity_id;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;

  typedef struct {
    int         due;
    int         h;
    string      tag;
    bit         care_pix;
    bit         care_hi;
    logic       pix;
    logic       hit;
    logic [3:0] id;
  } exp_t;

  exp_t sb[$];

  sprite_pixel_renderer #(
    .UPSCALE_FACTOR (5),
    .TILE_SIZE      (8),
    .SCREEN_H_PIX   (640),
    .SCREEN_V_PIX   (480)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .entity_in  (entity_in),
    .counter_H  (counter_H),
    .counter_V  (counter_V),
    .pixel_on   (pixel_on),
    .entity_hit (entity_hit),
    .entity_id  (entity_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [8:0] mk(input int row, input int id, input int o);
    logic [2:0] r;
    logic [3:0] i;
    logic [1:0] oo;
    r  = 3'(row);
    i  = 4'(id);
    oo = 2'(o);
    return {r, i, oo};
  endfunction

  // Reference: column from the absolute position within a line started at 0.
  function automatic exp_t model(input int h, input int v, input logic [8:0] ent);
    exp_t       e;
    logic [2:0] row, col, rowp, colp;
    logic [3:0] id;
    logic [7:0] rb;
    bit         ok;
    row  = ent[8:6];
    id   = ent[5:2];
    col  = 3'((h / 5) % 8);
    rowp = ent[1] ? 3'(7 - int'(row)) : row;
    colp = ent[0] ? 3'(7 - int'(col)) : col;
    case (id)
      4'd0:    rb = 8'hFF;
      4'd1:    rb = 8'h80 >> rowp;
      default: rb = 8'h00;
    endcase
    ok    = (ent != 9'h1FF) && (h < 640) && (v < 480);
    e.h   = h;
    e.due = 0;
    e.tag = "";
    e.care_pix = 1'b1;
    e.care_hi  = 1'b1;
    e.hit = ok;
    e.id  = ok ? id : 4'hF;
    e.pix = ok & rb[3'(7 - int'(colp))];
    return e;
  endfunction

  // Advance one cycle: return the expectation due now, then drive new inputs.
  task automatic step(input string tag, input int h, input int v, input logic [8:0] ent,
                      input bit care_pix, input bit care_hi,
                      output bit got, output exp_t want);
    exp_t e;
    @(negedge clk);
    got = 1'b0;
    want = model(0, 0, 9'h1FF);
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      want = sb.pop_front();
      got  = 1'b1;
    end
    counter_H = 10'(h);
    counter_V = 10'(v);
    entity_in = ent;
    e = model(h, v, ent);
    e.due = cyc + 2;
    e.tag = tag;
    e.care_pix = care_pix;
    e.care_hi  = care_hi;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    bit got;
    exp_t w;
    #1 reset = 1'b0;
    entity_in = 9'h1FF;
    repeat (3) begin
      @(negedge clk);
      compared++;
      if (pixel_on !== 1'b0 || entity_hit !== 1'b0 || entity_id !== 4'hF) begin
        failed++;
        $display("FAIL reset_hold: got pix=%b hit=%b id=%h want 0/0/F", pixel_on, entity_hit, entity_id);
      end
    end
    reset = 1'b1;
    for (int h = 0; h < 8; h++) begin
      step("reset_idle", h, 0, 9'h1FF, 1'b1, 1'b1, got, w);
      if (got) begin
        compared++;
        if (pixel_on !== w.pix || entity_hit !== w.hit || entity_id !== w.id) begin
          failed++;
          $display("FAIL %s h=%0d: got pix=%b hit=%b id=%h want %b/%b/%h",
                   w.tag, w.h, pixel_on, entity_hit, entity_id, w.pix, w.hit, w.id);
        end
      end
    end
  endtask

  task automatic test_solid();
    bit got;
    exp_t w;
    for (int h = 0; h < 42; h++) begin
      step("solid", h, 0, (h < 40) ? mk(0, 0, 0) : 9'h1FF, 1'b1, 1'b1, got, w);
      if (got) begin
        compared++;
        if (pixel_on !== w.pix || entity_hit !== w.hit || entity_id !== w.id) begin
          failed++;
          $display("FAIL %s h=%0d: got pix=%b hit=%b id=%h want %b/%b/%h",
                   w.tag, w.h, pixel_on, entity_hit, entity_id, w.pix, w.hit, w.id);
        end
      end
    end
  endtask

  task automatic test_diagonal();
    bit got;
    exp_t w;
    for (int o = 0; o < 4; o++) begin
      for (int h = 0; h < 80; h++) begin
        step($sformatf("diag_o%0d", o), h, 100, mk(3, 1, o), 1'b1, 1'b1, got, w);
        if (got) begin
          compared++;
          if (pixel_on !== w.pix || entity_hit !== w.hit || entity_id !== w.id) begin
            failed++;
            $display("FAIL %s h=%0d: got pix=%b hit=%b id=%h want %b/%b/%h",
                     w.tag, w.h, pixel_on, entity_hit, entity_id, w.pix, w.hit, w.id);
          end
        end
      end
    end
  endtask

  task automatic test_blanking();
    bit got;
    exp_t w;
    for (int h = 636; h < 646; h++) begin
      step("blank_h", h, 10, (h % 2 == 0) ? mk(0, 0, 0) : mk(2, 1, 1), 1'b1, 1'b1, got, w);
      if (got) begin
        compared++;
        if (pixel_on !== w.pix || entity_hit !== w.hit || entity_id !== w.id) begin
          failed++;
          $display("FAIL %s h=%0d: got pix=%b hit=%b id=%h want %b/%b/%h",
                   w.tag, w.h, pixel_on, entity_hit, entity_id, w.pix, w.hit, w.id);
        end
      end
    end
    for (int v = 477; v < 484; v++) begin
      step("blank_v", 0, v, mk(0, 0, 0), 1'b1, 1'b1, got, w);
      if (got) begin
        compared++;
        if (pixel_on !== w.pix || entity_hit !== w.hit || entity_id !== w.id) begin
          failed++;
          $display("FAIL %s v=%0d: got pix=%b hit=%b id=%h want %b/%b/%h",
                   w.tag, v, pixel_on, entity_hit, entity_id, w.pix, w.hit, w.id);
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    bit got;
    exp_t w;
    for (int h = 0; h < 18; h++) begin
      step("pre_reset", h, 200, mk(3, 1, 0), 1'b1, 1'b1, got, w);
      if (got) begin
        compared++;
        if (pixel_on !== w.pix || entity_hit !== w.hit || entity_id !== w.id) begin
          failed++;
          $display("FAIL %s h=%0d: got pix=%b hit=%b id=%h want %b/%b/%h",
                   w.tag, w.h, pixel_on, entity_hit, entity_id, w.pix, w.hit, w.id);
        end
      end
    end
    #1 reset = 1'b0;
    #1;
    compared++;
    if (pixel_on !== 1'b0 || entity_hit !== 1'b0 || entity_id !== 4'hF) begin
      failed++;
      $display("FAIL reset_async: got pix=%b hit=%b id=%h want 0/0/F", pixel_on, entity_hit, entity_id);
    end
    sb.delete();
    @(negedge clk);
    compared++;
    if (pixel_on !== 1'b0 || entity_hit !== 1'b0 || entity_id !== 4'hF) begin
      failed++;
      $display("FAIL reset_mid_hold: got pix=%b hit=%b id=%h want 0/0/F", pixel_on, entity_hit, entity_id);
    end
    reset = 1'b1;
    // Rest of this line: column untrusted, so only hit/ID are checked.
    for (int h = 18; h < 800; h++) begin
      step("post_reset_line", h, 200, mk(3, 1, 0), 1'b0, 1'b1, got, w);
      if (got && w.care_hi) begin
        compared++;
        if (entity_hit !== w.hit || entity_id !== w.id) begin
          failed++;
          $display("FAIL %s h=%0d: got hit=%b id=%h want %b/%h",
                   w.tag, w.h, entity_hit, entity_id, w.hit, w.id);
        end
      end
    end
    for (int h = 0; h < 80; h++) begin
      step("resync_line", h, 201, mk(3, 1, 0), 1'b1, 1'b1, got, w);
      if (got) begin
        if (w.care_hi) begin
          compared++;
          if (entity_hit !== w.hit || entity_id !== w.id) begin
            failed++;
            $display("FAIL %s h=%0d: got hit=%b id=%h want %b/%h",
                     w.tag, w.h, entity_hit, entity_id, w.hit, w.id);
          end
        end
        if (w.care_pix) begin
          compared++;
          if (pixel_on !== w.pix) begin
            failed++;
            $display("FAIL %s_pix h=%0d: got pix=%b want %b", w.tag, w.h, pixel_on, w.pix);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    exp_t w;
    logic [8:0] ent;
    int v;
    int ids[3] = '{0, 1, 15};
    for (int h = 0; h < 124; h++) begin
      if ($urandom_range(0, 5) == 0) ent = 9'h1FF;
      else ent = mk($urandom_range(0, 7), ids[$urandom_range(0, 2)], $urandom_range(0, 3));
      v = ($urandom_range(0, 7) == 0) ? 480 + $urandom_range(0, 40) : $urandom_range(0, 479);
      step("back_to_back", h, v, ent, 1'b1, 1'b1, got, w);
      if (got) begin
        compared++;
        if (pixel_on !== w.pix || entity_hit !== w.hit || entity_id !== w.id) begin
          failed++;
          $display("FAIL %s h=%0d: got pix=%b hit=%b id=%h want %b/%b/%h",
                   w.tag, w.h, pixel_on, entity_hit, entity_id, w.pix, w.hit, w.id);
        end
      end
    end
  endtask

  task automatic test_drain();
    bit got;
    exp_t w;
    repeat (3) begin
      step("drain", 700, 0, 9'h1FF, 1'b1, 1'b1, got, w);
      if (got) begin
        compared++;
        if (pixel_on !== w.pix || entity_hit !== w.hit || entity_id !== w.id) begin
          failed++;
          $display("FAIL %s h=%0d: got pix=%b hit=%b id=%h want %b/%b/%h",
                   w.tag, w.h, pixel_on, entity_hit, entity_id, w.pix, w.hit, w.id);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_solid();
    test_diagonal();
    test_blanking();
    test_reset_midline();
    test_back_to_back();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
